// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit between EX and a word-wide synchronous data memory.
// Performs LB/LH/LW/LBU/LHU/SB/SH/SW. Sub-word stores are read-modify-write.
// Misaligned requests are answered with resp_misalign and never reach memory.
//
// Ports
//   clk, rst         clock (rising edge), asynchronous active-low reset
//   req_valid/ready  request handshake; ready only while idle
//   req_we           1 = store, 0 = load
//   req_size         0 byte, 1 half, 2 word, 3 illegal
//   req_unsigned     zero-extend sub-word loads
//   req_addr         byte address
//   req_wdata        right-aligned store data
//   resp_valid       one-cycle completion pulse
//   resp_rdata       extended load data (0 for stores / misaligned)
//   resp_misalign    request was dropped as misaligned
//   busy             access in flight (PC stall)
//   mem_en/mem_we    memory strobe / write enable
//   mem_addr         word-aligned address
//   mem_wdata        full word to write
//   mem_rdata        read data, valid the cycle after a read strobe
module lsu_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_misalign,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, RESP} state_t;

  state_t            state;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [1:0]        lo_q;
  logic [DATA_W-1:0] wdata_q;

  logic              misalign;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merged;

  always_comb begin
    misalign = (req_size == 2'd3) ||
               (req_size == 2'd1 && req_addr[0]) ||
               (req_size == 2'd2 && req_addr[1:0] != 2'b00);
  end

  // Lane extraction for loads and lane merge for sub-word stores, both off
  // the word just returned by memory and the latched request.
  always_comb begin
    lane_b = mem_rdata[{lo_q, 3'b000} +: 8];
    lane_h = mem_rdata[{lo_q[1], 4'b0000} +: 16];
    case (size_q)
      2'd0:    load_data = {{24{~uns_q & lane_b[7]}}, lane_b};
      2'd1:    load_data = {{16{~uns_q & lane_h[15]}}, lane_h};
      default: load_data = mem_rdata;
    endcase
    merged = mem_rdata;
    case (size_q)
      2'd0:    merged[{lo_q, 3'b000} +: 8]    = wdata_q[7:0];
      2'd1:    merged[{lo_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  // All outputs are registered alongside the state. The asynchronous reset
  // clears mem_en/mem_we immediately, so an abort during WR drops the write
  // strobe without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      we_q          <= 1'b0;
      size_q        <= '0;
      uns_q         <= 1'b0;
      lo_q          <= '0;
      wdata_q       <= '0;
      req_ready     <= 1'b1;
      busy          <= 1'b0;
      resp_valid    <= 1'b0;
      resp_misalign <= 1'b0;
      resp_rdata    <= '0;
      mem_en        <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            size_q    <= req_size;
            uns_q     <= req_unsigned;
            lo_q      <= req_addr[1:0];
            wdata_q   <= req_wdata;
            mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (misalign) begin
              state         <= RESP;
              resp_valid    <= 1'b1;
              resp_misalign <= 1'b1;
              resp_rdata    <= '0;
            end else if (!req_we || req_size != 2'd2) begin
              state  <= RD;
              mem_en <= 1'b1;
              mem_we <= 1'b0;
            end else begin
              state     <= WR;
              mem_en    <= 1'b1;
              mem_we    <= 1'b1;
              mem_wdata <= req_wdata;
            end
          end
        end
        RD: begin
          state  <= RD_WAIT;
          mem_en <= 1'b0;
        end
        RD_WAIT: begin
          if (we_q) begin
            state     <= WR;
            mem_en    <= 1'b1;
            mem_we    <= 1'b1;
            mem_wdata <= merged;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= load_data;
          end
        end
        WR: begin
          state      <= RESP;
          mem_en     <= 1'b0;
          mem_we     <= 1'b0;
          resp_valid <= 1'b1;
          resp_rdata <= '0;
        end
        RESP: begin
          state         <= IDLE;
          resp_valid    <= 1'b0;
          resp_misalign <= 1'b0;
          resp_rdata    <= '0;
          busy          <= 1'b0;
          req_ready     <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Testbench for lsu_ctrl: table of directed load/store vectors checked for
// latency, returned data, misalign flag and memory access count, plus
// hand-written sequences for held req_valid and reset during a write.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_misalign, busy, mem_en, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

  lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misalign(resp_misalign), .busy(busy), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Word-wide synchronous memory model, 64 words indexed by address bits [7:2]
  logic [31:0] mem [0:63];
  logic [31:0] rdata_q;
  logic [31:0] last_waddr;
  int          acc_cnt;
  logic        bd_we;
  logic [5:0]  bd_idx;
  logic [31:0] bd_data;

  assign mem_rdata = rdata_q;

  initial begin
    acc_cnt    = 0;
    last_waddr = '0;
    rdata_q    = '0;
  end

  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] = bd_data;
    if (mem_en) begin
      acc_cnt++;
      if (mem_we) begin
        mem[mem_addr[7:2]] = mem_wdata;
        last_waddr = mem_addr;
      end else begin
        rdata_q <= mem[mem_addr[7:2]];
      end
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] data);
    @(negedge clk);
    bd_idx  = idx;
    bd_data = data;
    bd_we   = 1'b1;
    @(negedge clk);
    bd_we   = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    logic        mis;
    int          acc;
  } vec_t;

  function automatic vec_t mk(string nm, logic we, logic [1:0] sz, logic un,
                              logic [31:0] a, logic [31:0] wd, int lat,
                              logic [31:0] rd, logic mis, int acc);
    vec_t v;
    v.name = nm; v.we = we; v.size = sz; v.uns = un; v.addr = a; v.wdata = wd;
    v.lat = lat; v.rdata = rd; v.mis = mis; v.acc = acc;
    return v;
  endfunction

  // Issue one request and measure: latency = number of clock edges from the
  // accept edge to the edge at which resp_valid is sampled high.
  task automatic run_req(input vec_t v, output int lat, output logic [31:0] rd,
                         output logic mis, output int acc);
    int a0;
    lat = 0; rd = '0; mis = 1'b0; acc = 0;
    @(negedge clk);
    req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
    a0 = acc_cnt;
    @(posedge clk);
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (resp_valid) begin
        lat = n;
        rd  = resp_rdata;
        mis = resp_misalign;
        acc = acc_cnt - a0;
        break;
      end
    end
  endtask

  vec_t vecs[$];

  initial begin
    int          lat, acc, a0;
    logic [31:0] rd;
    logic        mis, seen;

    vecs.push_back(mk("sw10",   1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 2, 32'h0, 0, 1));
    vecs.push_back(mk("lw10",   0, 2'd2, 0, 32'h10, 32'h0, 3, 32'hDEADBEEF, 0, 1));
    vecs.push_back(mk("lb23",   0, 2'd0, 0, 32'h23, 32'h0, 3, 32'hFFFFFF80, 0, 1));
    vecs.push_back(mk("lbu23",  0, 2'd0, 1, 32'h23, 32'h0, 3, 32'h00000080, 0, 1));
    vecs.push_back(mk("lh20",   0, 2'd1, 0, 32'h20, 32'h0, 3, 32'h00007F01, 0, 1));
    vecs.push_back(mk("lh22",   0, 2'd1, 0, 32'h22, 32'h0, 3, 32'hFFFF80FF, 0, 1));
    vecs.push_back(mk("lhu22",  0, 2'd1, 1, 32'h22, 32'h0, 3, 32'h000080FF, 0, 1));
    vecs.push_back(mk("lb21",   0, 2'd0, 0, 32'h21, 32'h0, 3, 32'h0000007F, 0, 1));
    vecs.push_back(mk("lb22",   0, 2'd0, 0, 32'h22, 32'h0, 3, 32'hFFFFFFFF, 0, 1));
    vecs.push_back(mk("lbu20",  0, 2'd0, 1, 32'h20, 32'h0, 3, 32'h00000001, 0, 1));
    vecs.push_back(mk("sb31",   1, 2'd0, 0, 32'h31, 32'hFFFFFFAB, 4, 32'h0, 0, 2));
    vecs.push_back(mk("lw30a",  0, 2'd2, 0, 32'h30, 32'h0, 3, 32'h1122AB44, 0, 1));
    vecs.push_back(mk("sh32",   1, 2'd1, 0, 32'h32, 32'h1234CAFE, 4, 32'h0, 0, 2));
    vecs.push_back(mk("lw30b",  0, 2'd2, 0, 32'h30, 32'h0, 3, 32'hCAFEAB44, 0, 1));
    vecs.push_back(mk("sh30",   1, 2'd1, 0, 32'h30, 32'h00005A5A, 4, 32'h0, 0, 2));
    vecs.push_back(mk("sb33",   1, 2'd0, 0, 32'h33, 32'h00000099, 4, 32'h0, 0, 2));
    vecs.push_back(mk("lw30c",  0, 2'd2, 0, 32'h30, 32'h0, 3, 32'h99FE5A5A, 0, 1));
    vecs.push_back(mk("lh41",   0, 2'd1, 0, 32'h41, 32'h0, 1, 32'h0, 1, 0));
    vecs.push_back(mk("lw42",   0, 2'd2, 0, 32'h42, 32'h0, 1, 32'h0, 1, 0));
    vecs.push_back(mk("sw43",   1, 2'd2, 0, 32'h43, 32'hFFFFFFFF, 1, 32'h0, 1, 0));
    vecs.push_back(mk("size3",  0, 2'd3, 0, 32'h40, 32'h0, 1, 32'h0, 1, 0));
    vecs.push_back(mk("sh45",   1, 2'd1, 0, 32'h45, 32'h1111, 1, 32'h0, 1, 0));
    vecs.push_back(mk("swtop",  1, 2'd2, 0, 32'hFFFFFFFC, 32'h0BADF00D, 2, 32'h0, 0, 1));
    vecs.push_back(mk("lwtop",  0, 2'd2, 0, 32'hFFFFFFFC, 32'h0, 3, 32'h0BADF00D, 0, 1));
    vecs.push_back(mk("sbtop",  1, 2'd0, 0, 32'hFFFFFFFF, 32'h00000055, 4, 32'h0, 0, 2));
    vecs.push_back(mk("lwtop2", 0, 2'd2, 0, 32'hFFFFFFFC, 32'h0, 3, 32'h55ADF00D, 0, 1));
    vecs.push_back(mk("lhtop",  0, 2'd1, 0, 32'hFFFFFFFE, 32'h0, 3, 32'h000055AD, 0, 1));

    req_valid = 1'b0; req_we = 1'b0; req_size = '0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    bd_we = 1'b0; bd_idx = '0; bd_data = '0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_misalign", {31'b0, resp_misalign}, 32'd0);
    chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);

    rst = 1'b1;
    preload(6'd8,  32'h80FF7F01);
    preload(6'd12, 32'h11223344);
    preload(6'd20, 32'hA5A5A5A5);

    foreach (vecs[i]) begin
      run_req(vecs[i], lat, rd, mis, acc);
      chk({vecs[i].name, "_lat"}, lat, vecs[i].lat);
      chk({vecs[i].name, "_rdata"}, rd, vecs[i].rdata);
      chk({vecs[i].name, "_mis"}, {31'b0, mis}, {31'b0, vecs[i].mis});
      chk({vecs[i].name, "_acc"}, acc, vecs[i].acc);
      if (vecs[i].we && !vecs[i].mis)
        chk({vecs[i].name, "_waddr"}, last_waddr, vecs[i].addr & 32'hFFFFFFFC);
    end
    chk("mem30_final", mem[12], 32'h99FE5A5A);

    // req_valid held high across a load: one access, re-accept after RESP
    @(negedge clk);
    req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h10; req_valid = 1'b1;
    a0 = acc_cnt;
    @(posedge clk);
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      chk($sformatf("hold_busy_%0d", n), {31'b0, busy}, 32'd1);
      chk($sformatf("hold_ready_%0d", n), {31'b0, req_ready}, 32'd0);
    end
    chk("hold_resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("hold_rdata", resp_rdata, 32'hDEADBEEF);
    chk("hold_acc", acc_cnt - a0, 32'd1);
    @(negedge clk);
    chk("hold_idle_ready", {31'b0, req_ready}, 32'd1);
    chk("hold_idle_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    chk("hold_reaccept", {31'b0, busy}, 32'd1);
    req_valid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 8 && !seen; n++) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    chk("hold_drain", {31'b0, seen}, 32'd1);

    // Reset asserted while the SB write strobe is up
    @(negedge clk);
    req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h51; req_wdata = 32'h3C; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_we_before", {31'b0, mem_we}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("abort_we_dropped", {31'b0, mem_we}, 32'd0);
    chk("abort_en_dropped", {31'b0, mem_en}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    chk("abort_no_resp", {31'b0, seen}, 32'd0);
    chk("abort_ready", {31'b0, req_ready}, 32'd1);
    chk("abort_mem_kept", mem[20], 32'hA5A5A5A5);

    run_req(mk("lw50", 0, 2'd2, 0, 32'h50, 32'h0, 3, 32'hA5A5A5A5, 0, 1), lat, rd, mis, acc);
    chk("post_abort_lat", lat, 32'd3);
    chk("post_abort_rdata", rd, 32'hA5A5A5A5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
